// File: rtl/ctrl_pipe.sv
// Valid-tagged pipeline register chain with stall, flush and a saturating overrun counter.
// Optional one-entry skid buffer in front of stage 0 when CTRL_PIPE_SKID_EN is defined.
module ctrl_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             vld_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] dout,
  output logic             vld_out,
  output logic [CNT_W-1:0] ovr_cnt,
  output logic             busy
);

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [CNT_W-1:0] ovr_q;

  // Stage-0 source and drop qualifier, selected by the skid option
  logic             in_vld;
  logic [WIDTH-1:0] in_dat;
  logic             drop;

`ifdef CTRL_PIPE_SKID_EN
  logic [WIDTH-1:0] sd_q;
  logic             sv_q;

  always_comb begin
    in_vld = vld_in;
    in_dat = din;
    if (sv_q) begin
      in_vld = 1'b1;
      in_dat = sd_q;
    end
    drop = stall & ~flush & vld_in & sv_q;
    busy = (|v_q) | sv_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_q <= '0;
      sv_q <= 1'b0;
    end else if (flush) begin
      sd_q <= '0;
      sv_q <= 1'b0;
    end else if (stall) begin
      if (vld_in && !sv_q) begin
        sd_q <= din;
        sv_q <= 1'b1;
      end
    end else if (sv_q) begin
      // Skid drains into stage 0; a same-cycle arrival refills it
      if (vld_in) begin
        sd_q <= din;
      end else begin
        sv_q <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    in_vld = vld_in;
    in_dat = din;
    drop   = stall & ~flush & vld_in;
    busy   = |v_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
      v_q <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
      v_q <= '0;
    end else if (!stall) begin
      v_q[0] <= in_vld;
      if (in_vld) begin
        d_q[0] <= in_dat;
      end
      // Bubbles advance the valid bit but leave the data behind them untouched
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          d_q[k] <= d_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else if (cnt_clr) begin
      ovr_q <= '0;
    end else if (drop && (ovr_q != {CNT_W{1'b1}})) begin
      ovr_q <= ovr_q + CNT_W'(1);
    end
  end

  assign dout    = d_q[DEPTH-1];
  assign vld_out = v_q[DEPTH-1] & ~stall & ~flush;
  assign ovr_cnt = ovr_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: main instance (16b, depth 2) and a small one (8b, depth 1, 2b count).
// Expectations adapt to builds with CTRL_PIPE_SKID_EN defined.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  // Stall scenario drops 3 samples; with a skid the first is captured instead
  localparam logic [7:0] EXP_OVR = 8'(3 - SKID);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] din, dout;
  logic        vld_in, stall, flush, cnt_clr, vld_out, busy;
  logic [7:0]  ovr_cnt;

  logic [7:0]  b_din, b_dout;
  logic        b_vld_in, b_stall, b_flush, b_cnt_clr, b_vld_out, b_busy;
  logic [1:0]  b_ovr;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_pipe #(.WIDTH(16), .DEPTH(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .vld_in(vld_in), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .dout(dout), .vld_out(vld_out), .ovr_cnt(ovr_cnt), .busy(busy)
  );

  ctrl_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .din(b_din), .vld_in(b_vld_in), .stall(b_stall),
    .flush(b_flush), .cnt_clr(b_cnt_clr), .dout(b_dout), .vld_out(b_vld_out),
    .ovr_cnt(b_ovr), .busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic f,
                       input logic c);
    vld_in = v; din = d; stall = s; flush = f; cnt_clr = c;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    vld_in = 0; din = '0; stall = 0; flush = 0; cnt_clr = 0;
    b_vld_in = 0; b_din = '0; b_stall = 0; b_flush = 0; b_cnt_clr = 0;
    #3;
    n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL rst_dout got=%h want=0", dout); end
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL rst_vld got=%b want=0", vld_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_cmp++; if (ovr_cnt !== 8'h0) begin n_err++; $display("FAIL rst_ovr got=%h want=0", ovr_cnt); end
    n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL rst_b_busy got=%b want=0", b_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency;
    drive(1, 16'h1234, 0, 0, 0);
    tick;
    drive(0, 16'h0, 0, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lat_busy0 got=%b want=1", busy); end
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL lat_vld0 got=%b want=0", vld_out); end
    tick;
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL lat_vld1 got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h1234) begin n_err++; $display("FAIL lat_dout got=%h want=1234", dout); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lat_busy1 got=%b want=1", busy); end
    tick;
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL lat_vld2 got=%b want=0", vld_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lat_busy2 got=%b want=0", busy); end
    n_cmp++; if (dout !== 16'h1234) begin n_err++; $display("FAIL lat_hold got=%h want=1234", dout); end
  endtask

  task automatic test_bubble;
    logic        vin  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [15:0] dat  [9] = '{16'hAAAA, 0, 0, 0, 16'h5555, 0, 0, 0, 0};
    logic        ev   [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};
    logic [15:0] ed   [9] = '{16'h1234, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                              16'h5555, 16'h5555, 16'h5555, 16'h5555};
    int pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive(vin[i], dat[i], 0, 0, 0);
      tick;
      if (vld_out === 1'b1) pulses++;
      n_cmp++;
      if (vld_out !== ev[i]) begin
        n_err++; $display("FAIL bub_vld[%0d] got=%b want=%b", i, vld_out, ev[i]);
      end
      n_cmp++;
      if (dout !== ed[i]) begin
        n_err++; $display("FAIL bub_dout[%0d] got=%h want=%h", i, dout, ed[i]);
      end
    end
    n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL bub_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_stall;
    logic pat [5] = '{1, 0, 1, 1, 0};
    drive(1, 16'h0111, 0, 0, 0);
    tick;
    drive(1, 16'h0222, 0, 0, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      drive(pat[i], 16'h0D00 + 16'(i), 1, 0, 0);
      n_cmp++;
      if (vld_out !== 1'b0) begin n_err++; $display("FAIL st_vld[%0d] got=%b want=0", i, vld_out); end
      n_cmp++;
      if (dout !== 16'h0111) begin n_err++; $display("FAIL st_dout[%0d] got=%h want=0111", i, dout); end
      tick;
    end
    drive(0, 16'h0, 1, 0, 0);
    n_cmp++;
    if (ovr_cnt !== EXP_OVR) begin
      n_err++; $display("FAIL st_ovr got=%0d want=%0d", ovr_cnt, EXP_OVR);
    end
    drive(0, 16'h0, 0, 0, 0);
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL st_rel_vld got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h0111) begin n_err++; $display("FAIL st_rel_dout got=%h want=0111", dout); end
    tick;
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL st_nxt_vld got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h0222) begin n_err++; $display("FAIL st_nxt_dout got=%h want=0222", dout); end
    tick;
`ifdef CTRL_PIPE_SKID_EN
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL st_skid_vld got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h0D00) begin n_err++; $display("FAIL st_skid_dout got=%h want=0d00", dout); end
    tick;
`endif
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL st_end_vld got=%b want=0", vld_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL st_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_flush;
    drive(1, 16'h0A0A, 0, 0, 0);
    tick;
    drive(1, 16'h0B0B, 0, 0, 0);
    tick;
    drive(1, 16'h0C0C, 1, 1, 0);
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL fl_vld got=%b want=0", vld_out); end
    tick;
    drive(0, 16'h0, 0, 0, 0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fl_busy got=%b want=0", busy); end
    n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL fl_dout got=%h want=0", dout); end
    n_cmp++;
    if (ovr_cnt !== EXP_OVR) begin
      n_err++; $display("FAIL fl_ovr got=%0d want=%0d", ovr_cnt, EXP_OVR);
    end
    drive(0, 16'h0, 0, 0, 1);
    tick;
    drive(0, 16'h0, 0, 0, 0);
    n_cmp++; if (ovr_cnt !== 8'h0) begin n_err++; $display("FAIL fl_clr got=%0d want=0", ovr_cnt); end
  endtask

  task automatic test_depth1;
    b_vld_in = 1; b_din = 8'h5A; #1;
    n_cmp++; if (b_vld_out !== 1'b0) begin n_err++; $display("FAIL d1_vld0 got=%b want=0", b_vld_out); end
    tick;
    b_vld_in = 0; #1;
    n_cmp++; if (b_vld_out !== 1'b1) begin n_err++; $display("FAIL d1_vld1 got=%b want=1", b_vld_out); end
    n_cmp++; if (b_dout !== 8'h5A) begin n_err++; $display("FAIL d1_dout got=%h want=5a", b_dout); end
    tick;
    n_cmp++; if (b_vld_out !== 1'b0) begin n_err++; $display("FAIL d1_vld2 got=%b want=0", b_vld_out); end
    n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL d1_busy got=%b want=0", b_busy); end
    b_vld_in = 1; b_din = 8'h3C;
    tick;
    b_vld_in = 0; b_stall = 1; #1;
    n_cmp++; if (b_vld_out !== 1'b0) begin n_err++; $display("FAIL d1_stl got=%b want=0", b_vld_out); end
    n_cmp++; if (b_dout !== 8'h3C) begin n_err++; $display("FAIL d1_sdout got=%h want=3c", b_dout); end
    b_stall = 0; #1;
    n_cmp++; if (b_vld_out !== 1'b1) begin n_err++; $display("FAIL d1_rel got=%b want=1", b_vld_out); end
    tick;
  endtask

  task automatic test_saturation;
    b_stall = 1; b_vld_in = 1; b_din = 8'h77;
    for (int i = 0; i < 6 + SKID; i++) begin
      int e;
      tick;
      e = i + 1 - SKID;
      if (e > 3) e = 3;
      n_cmp++;
      if (b_ovr !== 2'(e)) begin n_err++; $display("FAIL sat[%0d] got=%0d want=%0d", i, b_ovr, e); end
    end
    b_cnt_clr = 1;
    tick;
    b_cnt_clr = 0; b_vld_in = 0; b_stall = 0; #1;
    n_cmp++; if (b_ovr !== 2'd0) begin n_err++; $display("FAIL sat_clr got=%0d want=0", b_ovr); end
    b_flush = 1;
    tick;
    b_flush = 0;
  endtask

`ifdef CTRL_PIPE_SKID_EN
  task automatic test_skid;
    drive(1, 16'h0BEE, 1, 0, 0);
    tick;
    drive(1, 16'h0C0F, 1, 0, 0);
    tick;
    drive(0, 16'h0, 1, 0, 0);
    n_cmp++; if (ovr_cnt !== 8'd1) begin n_err++; $display("FAIL sk_ovr got=%0d want=1", ovr_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sk_busy got=%b want=1", busy); end
    drive(0, 16'h0, 0, 0, 0);
    tick;
    tick;
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL sk_vld got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h0BEE) begin n_err++; $display("FAIL sk_dout got=%h want=0bee", dout); end
    tick;
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL sk_end got=%b want=0", vld_out); end
  endtask
`endif

  task automatic test_async_reset;
    drive(1, 16'h0F0F, 0, 0, 0);
    tick;
    drive(0, 16'h0, 0, 0, 0);
    tick;
    drive(1, 16'h0E0E, 1, 0, 0);
    tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_pre_busy got=%b want=1", busy); end
    n_cmp++; if (dout !== 16'h0F0F) begin n_err++; $display("FAIL ar_pre_dout got=%h want=0f0f", dout); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL ar_dout got=%h want=0", dout); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got=%b want=0", busy); end
    n_cmp++; if (ovr_cnt !== 8'h0) begin n_err++; $display("FAIL ar_ovr got=%0d want=0", ovr_cnt); end
    n_cmp++; if (vld_out !== 1'b0) begin n_err++; $display("FAIL ar_vld got=%b want=0", vld_out); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h0ABC, 0, 0, 0);
    tick;
    drive(0, 16'h0, 0, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_adv_busy got=%b want=1", busy); end
    tick;
    n_cmp++; if (vld_out !== 1'b1) begin n_err++; $display("FAIL ar_adv_vld got=%b want=1", vld_out); end
    n_cmp++; if (dout !== 16'h0ABC) begin n_err++; $display("FAIL ar_adv_dout got=%h want=0abc", dout); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bubble();
    test_stall();
    test_flush();
    test_depth1();
    test_saturation();
`ifdef CTRL_PIPE_SKID_EN
    test_skid();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
